// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-master Avalon arbiter.
package avalon_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;

  localparam int          PRIO_RR        = 0;
  localparam int          PRIO_FIXED     = 1;
  localparam logic [31:0] ABORT_READDATA = 32'h0;

  // One master's request as seen by the shared slave port
  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } av_req_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Saturating stall counter; expired flags the last permitted stalled grant cycle.
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int            CW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        count <= '0;
    else if (clear)                    count <= '0;
    else if (enable && count != LIMIT) count <= count + 1'b1;
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter onto one shared RAM port, with stall timeout
// and a sticky bus_error flag.
module avalon_bus_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int PRIORITY_MODE  = PRIO_RR,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic [31:0] s_readdata,
  input  logic        s_waitrequest,
  output logic        bus_error
);
  arb_state_t     state;
  logic           last_grant;  // 1 = m1 won the last arbitration
  logic           req0, req1, pick1, owner_req, expired, timeout;
  av_req_t [1:0]  mreq;
  av_req_t        fwd;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // A simultaneous read+write is treated as a write
  assign mreq[0] = '{address: m0_address, read: m0_read & ~m0_write, write: m0_write,
                     writedata: m0_writedata, byteenable: m0_byteenable};
  assign mreq[1] = '{address: m1_address, read: m1_read & ~m1_write, write: m1_write,
                     writedata: m1_writedata, byteenable: m1_byteenable};

  assign pick1     = (req0 && req1) ? ((PRIORITY_MODE == PRIO_FIXED) ? 1'b1 : ~last_grant) : req1;
  assign owner_req = (state == GRANT0 && req0) || (state == GRANT1 && req1);
  assign timeout   = (state != IDLE) && expired;

  arb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .enable  (owner_req & s_waitrequest),
    .clear   (state == IDLE),
    .expired (expired)
  );

  // Slave port stays all-zero unless the owner is actively requesting
  always_comb begin
    fwd = '0;
    if (state == GRANT0 && req0)      fwd = mreq[0];
    else if (state == GRANT1 && req1) fwd = mreq[1];
  end

  assign s_address    = fwd.address;
  assign s_read       = fwd.read;
  assign s_write      = fwd.write;
  assign s_writedata  = fwd.writedata;
  assign s_byteenable = fwd.byteenable;

  always_comb begin
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    if (state == GRANT0) begin
      m0_waitrequest = s_waitrequest & ~timeout;
      m0_readdata    = timeout ? ABORT_READDATA : s_readdata;
    end else if (state == GRANT1) begin
      m1_waitrequest = s_waitrequest & ~timeout;
      m1_readdata    = timeout ? ABORT_READDATA : s_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      bus_error  <= 1'b0;
    end else begin
      if (timeout) bus_error <= 1'b1;
      case (state)
        IDLE: if (req0 || req1) begin
          state      <= pick1 ? GRANT1 : GRANT0;
          last_grant <= pick1;
        end
        GRANT0, GRANT1: if (!owner_req || !s_waitrequest || timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Scoreboard bench: drivers push expected responses, a negedge monitor pops
// them on each completion; a RAM model with random stalls sits on the slave port.
module tb_avalon_bus_arbiter;
  import avalon_arb_pkg::*;

  localparam int TMO = 8;
  localparam logic [31:0] FP_A0 = 32'h0A0;
  localparam logic [31:0] FP_A1 = 32'h1B0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m0_address = '0, m1_address = '0, m0_writedata = '0, m1_writedata = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata, s_readdata;
  logic        m0_waitrequest, m1_waitrequest, s_read, s_write, s_waitrequest, bus_error;
  logic [3:0]  s_byteenable;

  logic        fp_m0_read = 1'b0, fp_m1_read = 1'b0;
  logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_s_address, fp_s_writedata;
  logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_s_read, fp_s_write, fp_bus_error;
  logic [3:0]  fp_s_byteenable;

  avalon_bus_arbiter #(.PRIORITY_MODE(PRIO_RR), .TIMEOUT_CYCLES(TMO)) u_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest), .bus_error(bus_error)
  );

  avalon_bus_arbiter #(.PRIORITY_MODE(PRIO_FIXED), .TIMEOUT_CYCLES(TMO)) u_fp (
    .clk(clk), .reset(reset),
    .m0_address(FP_A0), .m0_read(fp_m0_read), .m0_write(1'b0),
    .m0_writedata(32'h0), .m0_byteenable(4'hF),
    .m0_readdata(fp_m0_readdata), .m0_waitrequest(fp_m0_waitrequest),
    .m1_address(FP_A1), .m1_read(fp_m1_read), .m1_write(1'b0),
    .m1_writedata(32'h0), .m1_byteenable(4'hF),
    .m1_readdata(fp_m1_readdata), .m1_waitrequest(fp_m1_waitrequest),
    .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
    .s_writedata(fp_s_writedata), .s_byteenable(fp_s_byteenable),
    .s_readdata(32'h0), .s_waitrequest(1'b0), .bus_error(fp_bus_error)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h2402_0069;
    return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction

  // ---------------- slave RAM model ----------------
  logic [31:0] ram [0:1023];
  bit ram_ok = 1'b0, hang = 1'b0, slv_rand = 1'b0;
  int slv_wait = 0, wait_target = 0, swait_cnt = 0;

  assign s_waitrequest = hang || ((s_read || s_write) && (swait_cnt < wait_target));
  assign s_readdata    = (s_read && !s_waitrequest) ? ram[s_address[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (!ram_ok) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
      ram_ok <= 1'b1;
    end else if (s_write && !s_waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) ram[s_address[11:2]][8*b +: 8] <= s_writedata[8*b +: 8];
    end
    if ((s_read || s_write) && s_waitrequest) swait_cnt <= swait_cnt + 1;
    else swait_cnt <= 0;
    if (!(s_read || s_write)) wait_target <= slv_rand ? int'($urandom_range(0, 3)) : slv_wait;
  end

  // ---------------- scoreboard ----------------
  typedef struct { bit rd; logic [31:0] data; } exp_t;
  exp_t        q0[$], q1[$], mon_e;
  int          grant_log[$], grant_cyc[$];
  int          checks = 0, fails = 0, cyc_no = 0;
  logic [31:0] shadow [0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc_no++;
    if (reset) begin
      chk("s_rd_wr_exclusive", 32'(s_read & s_write), 32'h0);
      if (!(m0_read | m0_write | m1_read | m1_write))
        chk("s_idle_zero", 32'(s_read | s_write | (|s_address) | (|s_writedata) | (|s_byteenable)), 32'h0);
      if (!m0_waitrequest) begin
        chk("m0_owner_exclusive", 32'(m1_waitrequest), 32'h1);
        if (q0.size() == 0) begin
          fails++;
          $display("FAIL m0_unexpected_done: completion with no pending request");
        end else begin
          mon_e = q0.pop_front();
          if (mon_e.rd) chk("m0_readdata", m0_readdata, mon_e.data);
          grant_log.push_back(0);
          grant_cyc.push_back(cyc_no);
        end
      end else chk("m0_wait_readdata", m0_readdata, 32'h0);
      if (!m1_waitrequest) begin
        chk("m1_owner_exclusive", 32'(m0_waitrequest), 32'h1);
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL m1_unexpected_done: completion with no pending request");
        end else begin
          mon_e = q1.pop_front();
          if (mon_e.rd) chk("m1_readdata", m1_readdata, mon_e.data);
          grant_log.push_back(1);
          grant_cyc.push_back(cyc_no);
        end
      end else chk("m1_wait_readdata", m1_readdata, 32'h0);
    end
  end

  // ---------------- master driver ----------------
  task automatic issue(input int m, input bit wr, input bit both, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input bit abort,
                       output int cyc);
    exp_t e;
    int   w;
    w      = int'(addr[11:2]);
    e.rd   = !wr;
    e.data = abort ? ABORT_READDATA : shadow[w];
    if (wr && !abort)
      for (int b = 0; b < 4; b++) if (be[b]) shadow[w][8*b +: 8] = data[8*b +: 8];
    if (m == 0) begin
      q0.push_back(e);
      m0_address = addr; m0_writedata = data; m0_byteenable = be;
      m0_write = wr; m0_read = !wr || both;
    end else begin
      q1.push_back(e);
      m1_address = addr; m1_writedata = data; m1_byteenable = be;
      m1_write = wr; m1_read = !wr || both;
    end
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((m == 0) ? !m0_waitrequest : !m1_waitrequest) break;
      if (cyc >= 40) begin
        fails++;
        $display("FAIL m%0d_no_completion: still waiting after %0d cycles", m, cyc);
        break;
      end
    end
    @(posedge clk); #1;
    if (m == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
    else begin m1_read = 1'b0; m1_write = 1'b0; end
  endtask

  task automatic rand_traffic(input int m, input int n);
    int          c;
    bit          wr;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a  = 32'(m * 1024) + 32'($urandom_range(0, 255) * 4);
      wr = ($urandom_range(0, 1) == 1);
      issue(m, wr, wr && ($urandom_range(0, 3) == 0), a, $urandom, 4'($urandom), 1'b0, c);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, n;
    bit found;
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    repeat (3) @(negedge clk);
    chk("reset_m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("reset_m1_wait", 32'(m1_waitrequest), 32'h1);
    chk("reset_s_read", 32'(s_read), 32'h0);
    chk("reset_bus_error", 32'(bus_error), 32'h0);
    chk("reset_state", 32'(u_rr.state), 32'(IDLE));
    reset = 1'b1;
    @(posedge clk); #1;

    // Round-robin tie from reset: m0 first, strict alternation, one bubble
    slv_wait = 0;
    grant_log.delete(); grant_cyc.delete();
    fork
      for (int k = 0; k < 4; k++) issue(0, 1'b0, 1'b0, 32'h20 + 32'(4*k), 32'h0, 4'hF, 1'b0, c0);
      for (int k = 0; k < 4; k++) issue(1, 1'b0, 1'b0, 32'h40 + 32'(4*k), 32'h0, 4'hF, 1'b0, c1);
    join
    chk("rr_grant_count", grant_log.size(), 8);
    if (grant_log.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("rr_order", grant_log[k], k % 2);
      for (int k = 1; k < 8; k++) chk("rr_bubble", grant_cyc[k] - grant_cyc[k-1], 2);
    end

    // Single m0 read of 0x04 with one stall cycle
    slv_wait = 1;
    fork
      issue(0, 1'b0, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, c0);
      begin
        @(negedge clk);
        chk("lat_idle_s_read", 32'(s_read), 32'h0);
        chk("lat_idle_m0_wait", 32'(m0_waitrequest), 32'h1);
        @(negedge clk);
        chk("lat_s_address", s_address, 32'h4);
        chk("lat_s_read", 32'(s_read), 32'h1);
        chk("lat_m1_wait", 32'(m1_waitrequest), 32'h1);
      end
    join
    chk("m0_read_cycles", c0, 3);

    // Byte write from m1, then m0 reads it back
    fork
      issue(1, 1'b1, 1'b0, 32'h100, 32'h69, 4'b0001, 1'b0, c1);
      begin
        @(negedge clk); @(negedge clk);
        chk("wr_s_write", 32'(s_write), 32'h1);
        chk("wr_s_writedata", s_writedata, 32'h69);
        chk("wr_s_byteenable", 32'(s_byteenable), 32'h1);
      end
    join
    issue(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, c0);

    // read+write together forwards only the write
    fork
      issue(0, 1'b1, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF, 1'b0, c0);
      begin
        @(negedge clk); @(negedge clk);
        chk("both_s_read", 32'(s_read), 32'h0);
        chk("both_s_write", 32'(s_write), 32'h1);
      end
    join
    issue(1, 1'b0, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, c1);

    // Stalled slave: abort in the TMO-th grant cycle
    hang = 1'b1;
    issue(0, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1, c0);
    chk("tmo_cycles", c0, 1 + TMO);
    @(negedge clk);
    chk("tmo_bus_error", 32'(bus_error), 32'h1);
    hang = 1'b0;
    @(posedge clk); #1;
    issue(1, 1'b0, 1'b0, 32'hC, 32'h0, 4'hF, 1'b0, c1);
    chk("tmo_next_served", c1, 3);
    chk("bus_error_sticky", 32'(bus_error), 32'h1);

    // Reset in the middle of a stalled grant
    hang = 1'b1;
    m0_address = 32'h10; m0_read = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_s_read", 32'(s_read), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rst_s_read", 32'(s_read), 32'h0);
    chk("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("rst_state", 32'(u_rr.state), 32'(IDLE));
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    m0_read = 1'b0; hang = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    grant_log.delete(); grant_cyc.delete();
    fork
      issue(0, 1'b0, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0, c0);
      issue(1, 1'b0, 1'b0, 32'h18, 32'h0, 4'hF, 1'b0, c1);
    join
    chk("post_rst_first_m0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Random concurrent traffic in private regions with random stalls
    slv_rand = 1'b1;
    fork
      rand_traffic(0, 30);
      rand_traffic(1, 30);
    join
    slv_rand = 1'b0;

    // Fixed priority: m1 wins every tie while it keeps requesting
    @(posedge clk); #1;
    fp_m0_read = 1'b1; fp_m1_read = 1'b1; n = 0;
    repeat (30) begin
      @(negedge clk);
      if (fp_s_read) begin
        n++;
        chk("fp_grant_m1", fp_s_address, FP_A1);
        chk("fp_m1_wait", 32'(fp_m1_waitrequest), 32'h0);
      end
      chk("fp_m0_starved", 32'(fp_m0_waitrequest), 32'h1);
      chk("fp_m1_readdata", fp_m1_readdata, 32'h0);
      chk("fp_s_write", 32'(fp_s_write) | fp_s_writedata, 32'h0);
    end
    chk("fp_m1_grants", n, 15);
    fp_m1_read = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge clk);
      if (!fp_m0_waitrequest) begin
        found = 1'b1;
        chk("fp_m0_address", fp_s_address, FP_A0);
        chk("fp_m0_be", 32'(fp_s_byteenable), 32'hF);
        chk("fp_m0_readdata", fp_m0_readdata, 32'h0);
      end
    end
    chk("fp_m0_served", 32'(found), 32'h1);
    fp_m0_read = 1'b0;
    chk("fp_bus_error", 32'(fp_bus_error), 32'h0);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/avalon_bus_arbiter.md
AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 The block SHALL take parameter PRIORITY_MODE, default 0, meaning 0 = round-robin and 1 = fixed priority to m1.
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 1000, meaning the maximum number of granted cycles with s_waitrequest high before the access is aborted.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 m0_address/m1_address  input  32  byte address from master 0 (instruction fetch) / master 1 (load-store).
REQ-006 m0_read, m0_write / m1_read, m1_write  input  1 each  Avalon read/write requests.
REQ-007 m0_writedata/m1_writedata  input  32; m0_byteenable/m1_byteenable  input  4.
REQ-008 m0_readdata/m1_readdata  output  32; m0_waitrequest/m1_waitrequest  output  1.
REQ-009 s_address  output  32; s_read, s_write  output  1; s_writedata  output  32; s_byteenable  output  4  (shared RAM port).
REQ-010 s_readdata  input  32; s_waitrequest  input  1.
REQ-011 bus_error  output  1  sticky flag, set on timeout.

Function
REQ-012 A master SHALL be requesting when its read or write input is high.
REQ-013 The FSM SHALL have three states: IDLE, GRANT0 and GRANT1.
REQ-014 In IDLE with exactly one requester, the FSM SHALL move to that requester's GRANT state on the next edge.
REQ-015 In IDLE with both masters requesting, PRIORITY_MODE=1 SHALL grant m1; PRIORITY_MODE=0 SHALL grant the master not recorded in last_grant.
REQ-016 last_grant SHALL update on every IDLE-to-GRANT transition.
REQ-017 In GRANTx, the granted master's address, read, write, writedata and byteenable SHALL drive the s_* outputs combinationally.
REQ-018 In GRANTx, if the master asserts both read and write, s_write SHALL be forwarded and s_read SHALL be forced to 0.
REQ-019 In GRANTx, mx_waitrequest SHALL equal s_waitrequest, and mx_readdata SHALL equal s_readdata.
REQ-020 A GRANT state SHALL complete in the cycle s_waitrequest is low; the FSM SHALL return to IDLE on the next edge, giving one idle bubble between accesses.
REQ-021 Latency SHALL be as follows: a request first seen in IDLE at edge N appears on s_* after edge N+1; the minimum access is 2 cycles.
REQ-022 A non-granted master SHALL see waitrequest=1 and readdata=0 at all times, including while its request is pending in IDLE.
REQ-023 In IDLE, the s_* outputs SHALL be 0 (read=0, write=0, address=0, byteenable=0, writedata=0).
REQ-024 If the granted master drops read and write mid-grant, the FSM SHALL return to IDLE on the next edge and the s_* outputs SHALL be 0 from that cycle.
REQ-025 A counter SHALL increment each GRANT cycle with s_waitrequest high and SHALL clear in IDLE.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1, then in that cycle:
- the granted master SHALL see waitrequest=0 and readdata=0;
- bus_error SHALL set;
- the FSM SHALL return to IDLE on the next edge.
REQ-027 bus_error SHALL clear only on reset.
REQ-028 The counter width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits and SHALL NOT wrap.

Reset
REQ-029 Asserting reset low SHALL immediately force the following, with no access completed:
- state to IDLE;
- counter to 0;
- bus_error to 0;
- last_grant to m1, so that m0 wins the first tie;
- all s_* outputs to 0;
- m0_waitrequest and m1_waitrequest to 1;
- m0_readdata and m1_readdata to 0.
REQ-030 Reset asserted mid-grant SHALL abandon the access in the same way.
REQ-031 Deassertion SHALL take effect at the next rising clk edge.

Structure
REQ-032 Package avalon_arb_pkg SHALL hold:
- the state enum arb_state_t {IDLE, GRANT0, GRANT1};
- constants PRIO_RR=0 and PRIO_FIXED=1;
- constant ABORT_READDATA=32'h0.
REQ-033 The timeout counter SHALL be a sub-module arb_timeout_counter with ports clk, reset, enable, clear, expired and parameter TIMEOUT_CYCLES.

Verification
REQ-034 m0 read of 0x04 alone, with the RAM holding 0x24020069 and a 1-cycle waitrequest -> s_address=0x04 one cycle after the request; m0_readdata=0x24020069 with m0_waitrequest low; m1_waitrequest held at 1.
REQ-035 Both masters request together after reset, PRIORITY_MODE=0 -> grant order m0, m1, m0, m1 over four consecutive access pairs, with one IDLE cycle between grants.
REQ-036 Both masters request, PRIORITY_MODE=1 -> m1 granted every time while it keeps requesting; m0 served only when m1 is idle.
REQ-037 m1 write 0x00000069 to 0x100 with byteenable=4'b0001 -> s_write=1, s_writedata=0x69, s_byteenable=4'b0001; a subsequent m0 read of 0x100 returns 0x69 in byte 0.
REQ-038 s_waitrequest held at 1, TIMEOUT_CYCLES=8 -> the granted master's waitrequest drops in the 8th grant cycle with readdata=0; bus_error=1 and stays 1; the next request is still served.
REQ-039 reset pulsed low during GRANT0 with s_waitrequest high -> s_read=0, m0_waitrequest=1 and state IDLE immediately; after release, a simultaneous request is granted to m0 first.
